// File: rtl/rgbc_pkg.sv
// Shared types, channel ids and the saturating-add helper for the RGBC sample generator.
package rgbc_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SUM,
    SEND,
    GAP
  } state_t;

  localparam logic [2:0] CH_C   = 3'd0;
  localparam logic [2:0] CH_R   = 3'd1;
  localparam logic [2:0] CH_G   = 3'd2;
  localparam logic [2:0] CH_B   = 3'd3;
  localparam logic [2:0] CH_CHK = 3'd4;

  // Clamp a wide sum to the largest value representable in w bits (w <= 32).
  function automatic logic [31:0] sat_to_width(input logic [33:0] sum, input int unsigned w);
    logic [33:0] max_val;
    max_val = (34'd1 << w) - 34'd1;
    return (sum > max_val) ? max_val[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/rgbc_sat_sum.sv
// Combinational three-input adder that saturates at the all-ones DATA_W value.
module rgbc_sat_sum
  import rgbc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] sum
);

  logic [DATA_W+1:0] wide;

  // Two guard bits are enough for three addends, so the wide sum never overflows.
  assign wide = {2'b00, a} + {2'b00, b} + {2'b00, c};
  assign sum  = DATA_W'(sat_to_width(34'(wide), DATA_W));

endmodule

// File: rtl/rgbc_sample_gen.sv
// Emulated colour-sensor frame generator: captures LFSR words into R/G/B, streams C,R,G,B beats.
// Optional checksum beat (C^R^G^B, ch_id=4) is enabled by defining RGBC_FRAME_CHECKSUM_EN.
module rgbc_sample_gen
  import rgbc_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int GAP_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        gain,
  input  logic [DATA_W-1:0] rnd_data,
  output logic              rnd_en,
  output logic [DATA_W-1:0] ch_data,
  output logic [2:0]        ch_id,
  output logic              ch_valid,
  input  logic              ch_ready,
  output logic              frame_last,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              busy
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t            state;
  logic [1:0]        cap_idx;
  logic [1:0]        gain_q;
  logic [GAP_W-1:0]  gap_cnt;
  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] g_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] c_sum;
  logic [DATA_W-1:0] shifted;
`ifdef RGBC_FRAME_CHECKSUM_EN
  logic [DATA_W-1:0] c_q;
`endif

  assign shifted = rnd_data >> gain_q;

  rgbc_sat_sum #(.DATA_W(DATA_W)) u_sat_sum (
    .a  (r_q),
    .b  (g_q),
    .c  (b_q),
    .sum(c_sum)
  );

  // Outputs are registered alongside the state so each one changes only on a transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cap_idx    <= 2'd0;
      gain_q     <= 2'd0;
      gap_cnt    <= '0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
`ifdef RGBC_FRAME_CHECKSUM_EN
      c_q        <= '0;
`endif
      rnd_en     <= 1'b0;
      ch_data    <= '0;
      ch_id      <= CH_C;
      ch_valid   <= 1'b0;
      frame_last <= 1'b0;
      frame_cnt  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= CAPTURE;
            cap_idx <= 2'd0;
            gain_q  <= gain;
            rnd_en  <= 1'b1;
            busy    <= 1'b1;
          end
        end
        CAPTURE: begin
          case (cap_idx)
            2'd0:    r_q <= shifted;
            2'd1:    g_q <= shifted;
            default: b_q <= shifted;
          endcase
          if (cap_idx == 2'd2) begin
            state   <= SUM;
            cap_idx <= 2'd0;
            rnd_en  <= 1'b0;
          end else begin
            cap_idx <= cap_idx + 2'd1;
          end
        end
        SUM: begin
`ifdef RGBC_FRAME_CHECKSUM_EN
          c_q        <= c_sum;
`endif
          ch_data    <= c_sum;
          ch_id      <= CH_C;
          ch_valid   <= 1'b1;
          frame_last <= 1'b0;
          state      <= SEND;
        end
        SEND: begin
          if (ch_ready) begin
            if (frame_last) begin
              ch_valid   <= 1'b0;
              frame_last <= 1'b0;
              ch_id      <= CH_C;
              ch_data    <= '0;
              frame_cnt  <= frame_cnt + CNT_W'(1);
              if (!start) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else if (GAP_CYCLES == 0) begin
                state   <= CAPTURE;
                cap_idx <= 2'd0;
                gain_q  <= gain;
                rnd_en  <= 1'b1;
              end else begin
                state   <= GAP;
                gap_cnt <= '0;
              end
            end else begin
              case (ch_id)
                CH_C: begin
                  ch_data <= r_q;
                  ch_id   <= CH_R;
                end
                CH_R: begin
                  ch_data <= g_q;
                  ch_id   <= CH_G;
                end
                CH_G: begin
                  ch_data <= b_q;
                  ch_id   <= CH_B;
`ifndef RGBC_FRAME_CHECKSUM_EN
                  frame_last <= 1'b1;
`endif
                end
`ifdef RGBC_FRAME_CHECKSUM_EN
                CH_B: begin
                  ch_data    <= c_q ^ r_q ^ g_q ^ b_q;
                  ch_id      <= CH_CHK;
                  frame_last <= 1'b1;
                end
`endif
                default: ;
              endcase
            end
          end
        end
        GAP: begin
          // Dropping start here abandons the pending frame before any word is consumed.
          if (!start) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (gap_cnt == GAP_LAST) begin
            state   <= CAPTURE;
            cap_idx <= 2'd0;
            gain_q  <= gain;
            rnd_en  <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rgbc_sample_gen.md
Name: rgbc_sample_gen

Overview:
- Consumes the 16-bit pseudo-random word from the upstream LFSR and drives that LFSR's enable.
- Turns successive words into emulated colour-sensor frames: Clear, Red, Green, Blue channels.
- Streams each frame one channel per beat over a valid/ready handshake to the downstream sensor-interface model.
- Gain scaling, a saturating Clear channel and an inter-frame gap emulate sensor integration.

Parameters:
- DATA_W, 16, channel word width; equals LFSR width.
- GAP_CYCLES, 4, idle cycles between back-to-back frames; 0 allowed.
- CNT_W, 8, width of frame counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  level; 1 = keep generating frames.
- gain  in  2  right-shift applied to raw words; sampled once at frame start.
- rnd_data  in  DATA_W  current LFSR word.
- rnd_en  out  1  LFSR enable; one advance per captured word.
- ch_data  out  DATA_W  channel value.
- ch_id  out  3  0=C, 1=R, 2=G, 3=B, 4=checksum (optional feature only).
- ch_valid  out  1  beat valid.
- ch_ready  in  1  downstream accept.
- frame_last  out  1  marks final beat of a frame.
- frame_cnt  out  CNT_W  completed frames; wraps.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; capture index 0; gap counter 0; channel buffers 0. Reset is asynchronous, so ch_valid drops immediately even mid-frame. After release, generation resumes only via the IDLE path.
- FSM states: IDLE, CAPTURE, SUM, SEND, GAP.
- IDLE -> CAPTURE when start=1 (no leading gap). gain is latched on this transition.
- CAPTURE (3 cycles, index 0..2):
  - rnd_en=1 each cycle.
  - Store rnd_data >> gain_q into R, G, B in that order.
  - The value stored is the pre-advance word present in that cycle, so R/G/B equal three consecutive LFSR states.
  - rnd_en=0 in every other state.
- SUM (1 cycle): C = R+G+B computed at DATA_W+2 bits, saturated to 2^DATA_W-1.
- SEND:
  - Beats in order C, R, G, B; ch_valid=1 throughout.
  - ch_data, ch_id and frame_last hold stable while ch_valid && !ch_ready.
  - A beat advances only on ch_valid && ch_ready. No bubbles between beats when ch_ready stays high.
  - frame_last=1 on the B beat.
- Frame completion, on the last-beat handshake:
  - frame_cnt increments, wrapping at 2^CNT_W-1 -> 0.
  - If start=1: go to GAP, or directly to CAPTURE when GAP_CYCLES=0.
  - If start=0: go to IDLE.
- GAP: count GAP_CYCLES cycles with ch_valid=0, then CAPTURE. If start falls during GAP, go to IDLE on the next cycle.
- start falling during CAPTURE, SUM or SEND does not abort; the frame completes.
- Latency, start rise to first C beat valid: 4 cycles (3 CAPTURE + 1 SUM); C valid in the 5th cycle.
- Minimum frame period with ch_ready=1: 3+1+4+GAP_CYCLES cycles.

Optional Feature:
- Macro: RGBC_FRAME_CHECKSUM_EN.
- Defined: after B, a fifth beat with ch_id=4 and ch_data = C^R^G^B. frame_last moves from B to this beat. Frame period +1 cycle.
- Undefined: four beats only; ch_id never reaches 4; no checksum logic synthesised.

Decomposition:
- Package rgbc_pkg: state enum, ch_id constants (CH_C..CH_CHK), DATA_W default, saturating-add function.
- One natural sub-module, rgbc_sat_sum: combinational 3-input saturating adder. All remaining logic lives in a single module.

Test Plan:
- gain=0; rnd_data 0x1000, 0x2000, 0x3000 in the capture cycles -> beats C=0x6000, R=0x1000, G=0x2000, B=0x3000; frame_last on B; frame_cnt 0->1; rnd_en high exactly 3 cycles.
- Saturation: rnd_data 0xFFFF, 0x0001, 0x0000 -> C=0xFFFF. Also 0x8000, 0x8000, 0x0000 -> C=0xFFFF.
- gain=2; rnd_data 0x8000, 0x0400, 0x0007 -> R=0x2000, G=0x0100, B=0x0001, C=0x2101. Changing gain mid-frame has no effect until the next frame.
- Backpressure: ch_ready low for 5 cycles on the G beat -> G data and ch_id stable, no beat lost or duplicated. start held with GAP_CYCLES=4 -> exactly 4 idle cycles before the next rnd_en.
- Control events:
  - start dropped during SEND -> frame finishes, then IDLE with busy=0.
  - rst_n asserted during SEND -> ch_valid=0 immediately and frame_cnt=0.
  - frame_cnt wraps 255->0 after 256 frames.
- With RGBC_FRAME_CHECKSUM_EN and the inputs of the first scenario -> fifth beat ch_id=4, data 0x6000^0x1000^0x2000^0x3000=0x6000; frame_last only on the fifth beat.
